uart_tx_fifo: RTL and testbench

Transmit-side buffer and launch controller placed directly upstream of the UART transmitter. It accepts bytes from the host on a single-cycle write strobe, holds them in a power-of-two circular FIFO, and launches them one at a time into the transmitter with a one-cycle `tx_start` pulse plus held `tx_data`. It waits for the transmitter's `tx_done` pulse before launching the next byte.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-write / transmitter-launch bundle for uart_tx_fifo.
// slave is the FIFO side, master is the host plus transmitter side.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_done;
    logic                  busy;
    logic                  ovf;
    logic                  ovf_clr;

    modport slave (
        input  wr_en, wr_data, tx_done, ovf_clr,
        output full, empty, count, tx_start, tx_data, busy, ovf
    );

    modport master (
        output wr_en, wr_data, tx_done, ovf_clr,
        input  full, empty, count, tx_start, tx_data, busy, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter, one byte in flight at a time.
// Define UART_TX_FIFO_OVF_EN to enable the sticky write-overflow flag.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  tx_start_q;
    logic [7:0]            tx_data_q;
    logic                  full, empty, push, pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // A full FIFO rejects the write even if a pop frees a slot on the same edge.
    assign push  = bus.wr_en & ~full;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                busy_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (bus.tx_done) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                tx_data_q <= mem[rd_ptr];
            end
            count_q    <= count_d;
            state_q    <= state_d;
            busy_q     <= busy_d;
            tx_start_q <= pop;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      ovf_q <= 1'b0;
        else if (bus.wr_en && full)     ovf_q <= 1'b1;
        else if (bus.ovf_clr)           ovf_q <= 1'b0;
    end
    assign bus.ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf = 1'b0;
`endif

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of accepted bytes checked at each launch.
module tb_uart_tx_fifo;
    localparam int DL2 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] sb[$];
    logic prev_start = 1'b0;
    logic prev_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus();

    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accept) sb.push_back(b);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            tick();
        end
    endtask

    // Launch monitor: every tx_start must match the oldest accepted byte.
    always @(negedge clk) begin
        if (!reset && bus.tx_start) begin
            chk("start_single_cycle", {31'b0, prev_start}, 32'd0);
            chk("start_while_busy", {31'b0, prev_busy}, 32'd0);
            chk("sb_has_entry", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) chk("tx_data_order", {24'b0, bus.tx_data}, {24'b0, sb.pop_front()});
        end
        prev_start = bus.tx_start;
        prev_busy  = bus.busy;
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_done = 1'b0; bus.ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_empty", {31'b0, bus.empty}, 32'd1);
        chk("rst_full", {31'b0, bus.full}, 32'd0);
        chk("rst_count", {27'b0, bus.count}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        reset = 1'b0;
        tick();

        // single byte
        wr(8'hA5, 1'b1);
        chk("single_count_n", {27'b0, bus.count}, 32'd1);
        chk("single_start_n", {31'b0, bus.tx_start}, 32'd0);
        tick();
        chk("single_start_n1", {31'b0, bus.tx_start}, 32'd1);
        chk("single_data", {24'b0, bus.tx_data}, 32'hA5);
        chk("single_busy", {31'b0, bus.busy}, 32'd1);
        chk("single_count0", {27'b0, bus.count}, 32'd0);
        tick();
        chk("single_start_n2", {31'b0, bus.tx_start}, 32'd0);
        chk("single_busy_hold", {31'b0, bus.busy}, 32'd1);
        drain(1);
        chk("single_idle", {31'b0, bus.busy}, 32'd0);
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0; tick();
        chk("idle_done_ignored", {31'b0, bus.busy | bus.tx_start}, 32'd0);

        // burst against a stalled transmitter
        for (int i = 1; i <= 16; i++) wr(8'(i), 1'b1);
        chk("burst_count15", {27'b0, bus.count}, 32'd15);
        chk("burst_not_full", {31'b0, bus.full}, 32'd0);
        wr(8'h11, 1'b1);
        chk("burst_count16", {27'b0, bus.count}, 32'd16);
        chk("burst_full", {31'b0, bus.full}, 32'd1);

        // overflow
        wr(8'hFF, 1'b0);
        chk("ovf_count", {27'b0, bus.count}, 32'd16);
        chk("ovf_set", {31'b0, bus.ovf}, {31'b0, OVF_ON});
        tick();
        chk("ovf_sticky", {31'b0, bus.ovf}, {31'b0, OVF_ON});
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
        chk("ovf_clr", {31'b0, bus.ovf}, 32'd0);
        bus.ovf_clr = 1'b1; wr(8'hFE, 1'b0); bus.ovf_clr = 1'b0;
        chk("ovf_set_wins", {31'b0, bus.ovf}, {31'b0, OVF_ON});
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;

        drain(17);
        chk("burst_drained", {27'b0, bus.count}, 32'd0);
        chk("burst_sb_empty", sb.size(), 32'd0);
        chk("burst_idle", {31'b0, bus.busy}, 32'd0);

        // simultaneous push and pop with count 3 in IDLE
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i), 1'b1);
        chk("pp_count3", {27'b0, bus.count}, 32'd3);
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        chk("pp_idle_count3", {27'b0, bus.count}, 32'd3);
        wr(8'hB4, 1'b1);
        chk("pp_count_hold", {27'b0, bus.count}, 32'd3);
        chk("pp_launch", {31'b0, bus.tx_start}, 32'd1);
        drain(4);
        chk("pp_drained", sb.size(), 32'd0);

        // wrap-around: 40 bytes streamed with steady occupancy
        for (int i = 0; i < 10; i++) wr(8'(i * 7 + 3), 1'b1);
        chk("wrap_fill", {27'b0, bus.count}, 32'd9);
        for (int i = 10; i < 40; i++) begin
            bus.tx_done = 1'b1;
            wr(8'(i * 7 + 3), 1'b1);
            bus.tx_done = 1'b0;
            tick();
            if (i % 10 == 0) chk("wrap_count", {27'b0, bus.count}, 32'd9);
        end
        drain(10);
        chk("wrap_drained", sb.size(), 32'd0);
        chk("wrap_empty", {31'b0, bus.empty}, 32'd1);

        // reset in mid-frame
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), 1'b1);
        chk("mid_busy", {31'b0, bus.busy}, 32'd1);
        chk("mid_count5", {27'b0, bus.count}, 32'd5);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_count", {27'b0, bus.count}, 32'd0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mid_rst_empty", {31'b0, bus.empty}, 32'd1);
        chk("mid_rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        chk("mid_rst_start", {31'b0, bus.tx_start}, 32'd0);
        tick();
        reset = 1'b0;
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0; tick();
        chk("mid_done_ignored", {31'b0, bus.busy | bus.tx_start}, 32'd0);
        wr(8'h5A, 1'b1);
        tick();
        chk("mid_relaunch", {31'b0, bus.tx_start}, 32'd1);
        drain(1);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
